// File: rtl/ex_fwd_ctrl.sv
// ex_fwd_ctrl: EX-stage operand forwarding selects and load-use stall control
module ex_fwd_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_ID,
  input  logic [REG_AW-1:0] rt_ID,
  input  logic              rs_used_ID,
  input  logic              rt_used_ID,
  input  logic [REG_AW-1:0] rw_ID,
  input  logic              RegWr_ID,
  input  logic              MemtoReg_ID,
  input  logic              flush_ID,
  input  logic              hold_in,
  output logic [1:0]        BusAFW,
  output logic [1:0]        BusBFW,
  output logic              stall_IFID,
  output logic              bubble_EX,
  output logic [CNT_W-1:0]  luse_count
);
  logic [REG_AW-1:0] rw_ex, rw_m;
  logic reg_wr_ex, mem_to_reg_ex, reg_wr_m;
  logic luse, kill;
  logic [1:0] sel_a, sel_b;
  // a load in EX is never forwarded from ALUout; it stalls and forwards from WB next cycle
  always_comb begin
    luse = mem_to_reg_ex & reg_wr_ex & (rw_ex != '0) &
           ((rs_used_ID & (rs_ID == rw_ex)) | (rt_used_ID & (rt_ID == rw_ex)));
    sel_a = (reg_wr_ex & !mem_to_reg_ex & (rw_ex != '0) & rs_used_ID & (rs_ID == rw_ex)) ? 2'b10 :
            (reg_wr_m & (rw_m != '0) & rs_used_ID & (rs_ID == rw_m)) ? 2'b01 : 2'b00;
    sel_b = (reg_wr_ex & !mem_to_reg_ex & (rw_ex != '0) & rt_used_ID & (rt_ID == rw_ex)) ? 2'b10 :
            (reg_wr_m & (rw_m != '0) & rt_used_ID & (rt_ID == rw_m)) ? 2'b01 : 2'b00;
    kill = luse | flush_ID;
  end
  assign stall_IFID = luse;
  assign bubble_EX  = luse;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_ex         <= '0;
      reg_wr_ex     <= 1'b0;
      mem_to_reg_ex <= 1'b0;
      rw_m          <= '0;
      reg_wr_m      <= 1'b0;
      BusAFW        <= 2'b00;
      BusBFW        <= 2'b00;
      luse_count    <= '0;
    end else if (!hold_in) begin
      rw_ex         <= kill ? '0 : rw_ID;
      reg_wr_ex     <= kill ? 1'b0 : RegWr_ID;
      mem_to_reg_ex <= kill ? 1'b0 : MemtoReg_ID;
      rw_m          <= rw_ex;
      reg_wr_m      <= reg_wr_ex;
      BusAFW        <= kill ? 2'b00 : sel_a;
      BusBFW        <= kill ? 2'b00 : sel_b;
      if (luse && !(&luse_count)) luse_count <= luse_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// tb_ex_fwd_ctrl: directed scoreboard bench for the forwarding/load-use controller
module tb_ex_fwd_ctrl;
  localparam int CW = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rs_ID = '0, rt_ID = '0, rw_ID = '0;
  logic rs_used_ID = 1'b0, rt_used_ID = 1'b0, RegWr_ID = 1'b0, MemtoReg_ID = 1'b0;
  logic flush_ID = 1'b0, hold_in = 1'b0;
  logic [1:0] BusAFW, BusBFW;
  logic stall_IFID, bubble_EX;
  logic [CW-1:0] luse_count;
  int checks = 0, errors = 0;
  logic [3:0] sb[$];

  ex_fwd_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rs_ID(rs_ID), .rt_ID(rt_ID), .rs_used_ID(rs_used_ID),
    .rt_used_ID(rt_used_ID), .rw_ID(rw_ID), .RegWr_ID(RegWr_ID), .MemtoReg_ID(MemtoReg_ID),
    .flush_ID(flush_ID), .hold_in(hold_in), .BusAFW(BusAFW), .BusBFW(BusBFW),
    .stall_IFID(stall_IFID), .bubble_EX(bubble_EX), .luse_count(luse_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic rsu, input logic rtu,
                       input logic [4:0] rw, input logic rwr, input logic mtr, input logic fl,
                       input logic hd);
    rs_ID = rs; rt_ID = rt; rs_used_ID = rsu; rt_used_ID = rtu;
    rw_ID = rw; RegWr_ID = rwr; MemtoReg_ID = mtr; flush_ID = fl; hold_in = hd;
  endtask

  task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                      input logic rsu, input logic rtu, input logic [4:0] rw, input logic rwr,
                      input logic mtr, input logic fl, input logic hd,
                      input logic est, input logic [1:0] ea, input logic [1:0] eb);
    logic [3:0] e;
    drive(rs, rt, rsu, rtu, rw, rwr, mtr, fl, hd);
    sb.push_back({ea, eb});
    #1;
    chk({tag, ".stall"}, stall_IFID, est);
    chk({tag, ".bubble"}, bubble_EX, est);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".busA"}, BusAFW, e[3:2]);
    chk({tag, ".busB"}, BusBFW, e[1:0]);
  endtask

  initial begin
    #2;
    chk("rst.busA", BusAFW, 2'b00);
    chk("rst.busB", BusBFW, 2'b00);
    chk("rst.stall", stall_IFID, 1'b0);
    chk("rst.count", luse_count, 0);
    #10 rst = 1'b0;
    //          tag    rs  rt  rsu rtu rw  rwr mtr fl hd  st  A      B
    step("add3",    1,  2,  1,  1,  3,  1,  0, 0, 0, 0, 2'b00, 2'b00);
    step("adj",     3,  4,  1,  1,  6,  1,  0, 0, 0, 0, 2'b10, 2'b00);
    step("p5",      8,  9,  1,  1,  5,  1,  0, 0, 0, 0, 2'b00, 2'b00);
    step("ind",    10, 11,  1,  1, 12,  1,  0, 0, 0, 0, 2'b00, 2'b00);
    step("gap1",   13,  5,  1,  1, 14,  1,  0, 0, 0, 0, 2'b00, 2'b01);
    step("p0",      1,  2,  1,  1,  0,  1,  0, 0, 0, 0, 2'b00, 2'b00);
    step("fill",   20, 21,  1,  1, 15,  1,  0, 0, 0, 0, 2'b00, 2'b00);
    step("r0use",   0,  0,  1,  1,  4,  1,  0, 0, 0, 0, 2'b00, 2'b00);
    step("p4b",     1,  2,  1,  1,  4,  1,  0, 0, 0, 0, 2'b00, 2'b00);
    step("dbl",     4,  4,  1,  0,  0,  0,  0, 0, 0, 0, 2'b10, 2'b00);
    step("lw7",     1,  2,  1,  1,  7,  1,  1, 0, 0, 0, 2'b00, 2'b00);
    step("luse",    7,  3,  1,  1,  8,  1,  0, 0, 0, 1, 2'b00, 2'b00);
    chk("luse.count1", luse_count, 1);
    step("luse2",   7,  3,  1,  1,  8,  1,  0, 0, 0, 0, 2'b01, 2'b00);
    chk("luse2.count", luse_count, 1);
    step("lw9",     8,  2,  1,  1,  9,  1,  1, 0, 0, 0, 2'b10, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step("hold",  8,  9,  1,  1, 10,  1,  0, 0, 1, 1, 2'b10, 2'b00);
      chk("hold.count", luse_count, 1);
    end
    step("rel",     8,  9,  1,  1, 10,  1,  0, 0, 0, 1, 2'b00, 2'b00);
    chk("rel.count", luse_count, 2);
    step("rel2",    8,  9,  1,  1, 10,  1,  0, 0, 0, 0, 2'b00, 2'b01);
    step("flush",  10,  3,  1,  1, 10,  1,  0, 1, 0, 0, 2'b00, 2'b00);
    step("postfl", 10,  0,  1,  1,  0,  0,  0, 0, 0, 0, 2'b01, 2'b00);
    step("lw11",    1,  2,  1,  1, 11,  1,  1, 0, 0, 0, 2'b00, 2'b00);
    step("lufl",   11,  3,  1,  1, 12,  1,  0, 1, 0, 1, 2'b00, 2'b00);
    chk("lufl.count", luse_count, 3);
    step("postlf", 11,  3,  1,  1, 12,  1,  0, 0, 0, 0, 2'b01, 2'b00);
    // drive load-use pairs until the counter is one short of all-ones
    for (int i = 0; i < 251; i++) begin
      drive(0, 0, 0, 0, 7, 1, 1, 0, 0);
      @(posedge clk); #1;
      drive(7, 0, 1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    chk("sat.fe", luse_count, 8'hFE);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 7, 1, 1, 0, 0);
      @(posedge clk); #1;
      drive(7, 0, 1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("sat.ff", luse_count, 8'hFF);
    end
    step("ar3",     1,  2,  1,  1,  3,  1,  0, 0, 0, 0, 2'b00, 2'b00);
    step("lwr7",    3,  2,  1,  1,  7,  1,  1, 0, 0, 0, 2'b10, 2'b00);
    drive(7, 0, 1, 0, 8, 1, 0, 0, 0);
    #1;
    chk("pre.stall", stall_IFID, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst.stall", stall_IFID, 1'b0);
    chk("arst.bubble", bubble_EX, 1'b0);
    chk("arst.busA", BusAFW, 2'b00);
    chk("arst.count", luse_count, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post.stall", stall_IFID, 1'b0);
    chk("post.busA", BusAFW, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
